// File: rtl/bfis_query_ctrl_pkg.sv
// Shared types and constants for the bfis host query sequencer.
package bfis_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] SYNC_WORD = 32'hFFFF_FFFF;

    // k is limited by the result buffer depth; a zero k is rejected by the caller.
    function automatic logic [15:0] clamp_k(input logic [15:0] k_raw, input int unsigned k_max);
        if (32'(k_raw) > k_max) begin
            return 16'(k_max);
        end
        return k_raw;
    endfunction

endpackage

// File: rtl/bfis_query_ctrl_toggle_edge.sv
// Toggle-to-pulse converter: edge_o is high in any cycle where tog_i differs from its registered copy.
module toggle_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tog_i,
    output logic edge_o
);

    logic tog_q;

    // The copy follows the input during reset too, so no edge is seen when reset releases.
    always_ff @(posedge clk_i) begin
        tog_q <= tog_i;
    end

    assign edge_o = (tog_i ^ tog_q) & ~rst_i;

endmodule

// File: rtl/bfis_query_ctrl.sv
// Host-side query sequencer for bfis: loads a framed query, issues it, buffers k results, drains them on acks.
// Optional WAIT watchdog enabled by defining BFIS_CTRL_TIMEOUT_EN.
module bfis_query_ctrl
    import bfis_ctrl_pkg::*;
#(
    parameter int DIM            = 4,
    parameter int K_MAX          = 4,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           host_word_in,
    input  logic                  host_strobe_in,
    input  logic                  host_ack_in,
    output logic [DIM-1:0][31:0]  query_out,
    output logic [15:0]           k_out,
    output logic                  query_valid_out,
    input  logic [31:0]           result_in,
    input  logic                  result_valid_in,
    output logic [31:0]           result_out,
    output logic                  result_ready_out,
    output logic [2:0]            state_out,
    output logic                  err_out
);

    localparam int CW = $clog2(DIM + 2);
    localparam int KW = $clog2(K_MAX + 1);

    if (DIM < 1 || K_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("bfis_query_ctrl: DIM, K_MAX and TIMEOUT_CYCLES must all be at least 1");
    end

    logic strobe_edge, ack_edge;
    logic sync_acc, word_acc;

    toggle_edge u_strobe_edge (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .tog_i  (host_strobe_in),
        .edge_o (strobe_edge)
    );

    toggle_edge u_ack_edge (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .tog_i  (host_ack_in),
        .edge_o (ack_edge)
    );

    assign sync_acc = strobe_edge && (host_word_in == SYNC_WORD);
    assign word_acc = strobe_edge && (host_word_in != SYNC_WORD);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [KW-1:0]        wcnt_q, rptr_q, k_q;
    logic [KW-1:0]        wcnt_d, rptr_d;
    logic [DIM-1:0][31:0] slot_q;
    logic [DIM-1:0][31:0] query_q;
    logic [15:0]          k_out_q;
    logic                 qv_q;
    logic [31:0]          res_q;
    logic                 rdy_q;
    logic                 err_q;
    logic [31:0]          res_buf_q [K_MAX];
    logic [31:0]          rd_next;
    logic [15:0]          k_clamped;

`ifdef BFIS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;
`endif

    assign wcnt_d    = wcnt_q + KW'(1);
    assign rptr_d    = rptr_q + KW'(1);
    assign k_clamped = clamp_k(host_word_in[15:0], K_MAX);

    always_comb begin
        rd_next = res_buf_q[0];
        for (int i = 0; i < K_MAX; i++) begin
            if (rptr_d == KW'(i)) begin
                rd_next = res_buf_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            rptr_q  <= '0;
            k_q     <= '0;
            query_q <= '0;
            k_out_q <= '0;
            qv_q    <= 1'b0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef BFIS_CTRL_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            qv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sync_acc) begin
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (sync_acc) begin
                        err_q <= 1'b0;
                        cnt_q <= '0;
                    end else if (word_acc) begin
                        if (cnt_q == CW'(DIM)) begin
                            // The k word: outputs are registered here so the pulse lands in ISSUE.
                            state_q <= S_ISSUE;
                            if (host_word_in[15:0] == 16'd0) begin
                                err_q <= 1'b1;
                            end else begin
                                query_q <= slot_q;
                                k_out_q <= k_clamped;
                                k_q     <= KW'(k_clamped);
                                qv_q    <= 1'b1;
                            end
                        end else begin
                            for (int i = 0; i < DIM; i++) begin
                                if (cnt_q == CW'(i)) begin
                                    slot_q[i] <= host_word_in;
                                end
                            end
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    wcnt_q  <= '0;
`ifdef BFIS_CTRL_TIMEOUT_EN
                    tcnt_q  <= '0;
`endif
                    state_q <= qv_q ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (sync_acc) begin
                        err_q <= 1'b1;
                    end
`ifdef BFIS_CTRL_TIMEOUT_EN
                    tcnt_q <= tcnt_q + TW'(1);
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        if (wcnt_q == '0) begin
                            state_q <= S_IDLE;
                        end else begin
                            k_q     <= wcnt_q;
                            rptr_q  <= '0;
                            res_q   <= res_buf_q[0];
                            rdy_q   <= 1'b1;
                            state_q <= S_DRAIN;
                        end
                    end else
`endif
                    if (result_valid_in) begin
                        for (int i = 0; i < K_MAX; i++) begin
                            if (wcnt_q == KW'(i)) begin
                                res_buf_q[i] <= result_in;
                            end
                        end
                        wcnt_q <= wcnt_d;
                        if (wcnt_d == k_q) begin
                            // Entry 0 may be the beat arriving right now.
                            res_q   <= (wcnt_q == '0) ? result_in : res_buf_q[0];
                            rptr_q  <= '0;
                            rdy_q   <= 1'b1;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (sync_acc) begin
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        rptr_q  <= '0;
                        wcnt_q  <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end else if (ack_edge) begin
                        if (rptr_d == k_q) begin
                            rdy_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            rptr_q <= rptr_d;
                            res_q  <= rd_next;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign query_out        = query_q;
    assign k_out            = k_out_q;
    assign query_valid_out  = qv_q;
    assign result_out       = res_q;
    assign result_ready_out = rdy_q;
    assign state_out        = state_q;
    assign err_out          = err_q;

endmodule

// File: tb/tb_bfis_query_ctrl.sv
// Randomized scoreboard bench for bfis_query_ctrl; the timeout scenario runs when BFIS_CTRL_TIMEOUT_EN is defined.
module tb_bfis_query_ctrl;

    localparam int DIM            = 4;
    localparam int K_MAX          = 4;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int IW             = DIM * 32 + 16;
    localparam logic [31:0] SYNC  = 32'hFFFF_FFFF;

    logic                 clk;
    logic                 rst_in;
    logic [31:0]          host_word_in;
    logic                 host_strobe_in;
    logic                 host_ack_in;
    logic [DIM-1:0][31:0] query_out;
    logic [15:0]          k_out;
    logic                 query_valid_out;
    logic [31:0]          result_in;
    logic                 result_valid_in;
    logic [31:0]          result_out;
    logic                 result_ready_out;
    logic [2:0]           state_out;
    logic                 err_out;

    bfis_query_ctrl #(
        .DIM            (DIM),
        .K_MAX          (K_MAX),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .host_word_in     (host_word_in),
        .host_strobe_in   (host_strobe_in),
        .host_ack_in      (host_ack_in),
        .query_out        (query_out),
        .k_out            (k_out),
        .query_valid_out  (query_valid_out),
        .result_in        (result_in),
        .result_valid_in  (result_valid_in),
        .result_out       (result_out),
        .result_ready_out (result_ready_out),
        .state_out        (state_out),
        .err_out          (err_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [IW-1:0] exp_issue_q[$];
    logic [31:0]   exp_q[$];
    logic          err_exp = 1'b0;
    bit            in_load = 1'b0;
    logic [31:0]   beat_vals [8];

    function automatic void check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [IW-1:0] pack_issue(input logic [31:0] q [DIM], input int k);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) r[16 + 32 * i +: 32] = q[i];
        r[15:0] = 16'(k);
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SYNC) w = 32'd0;
        return w;
    endfunction

    // ---------------- monitor ----------------
    logic ready_prev = 1'b0;
    logic valid_prev = 1'b0;
    logic ack_s1 = 1'b0;
    logic ack_s2 = 1'b0;

    always @(negedge clk) begin
        if (query_valid_out) begin
            check("issue_pulse_width", {{(IW-1){1'b0}}, valid_prev}, '0);
            if (exp_issue_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got query pulse k=%0d expected none", k_out);
            end else begin
                check("issue", {query_out, k_out}, exp_issue_q.pop_front());
            end
        end
        // A new entry is on result_out when ready rises or after an ack taken in the previous cycle.
        if (result_ready_out && (!ready_prev || (ack_s1 != ack_s2))) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", result_out);
            end else begin
                check("result", {{(IW-32){1'b0}}, result_out}, {{(IW-32){1'b0}}, exp_q.pop_front()});
            end
        end
        valid_prev = query_valid_out;
        ready_prev = result_ready_out;
        ack_s2     = ack_s1;
        ack_s1     = host_ack_in;
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w);
        @(posedge clk); #1;
        host_word_in   = w;
        host_strobe_in = ~host_strobe_in;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                result_valid_in = 1'b0;
            end
            @(posedge clk); #1;
            result_in       = beat_vals[i];
            result_valid_in = 1'b1;
        end
        @(posedge clk); #1;
        result_valid_in = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int guard = 0;
        while (!result_ready_out && guard < budget) begin
            @(posedge clk); #1;
            guard++;
        end
        ok = result_ready_out;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_wait: got result_ready_out=0 after %0d cycles expected 1", budget);
        end
    endtask

    task automatic drain(input int n_acks, input bit abort, input int budget);
        bit ok;
        wait_ready(budget, ok);
        if (!ok) return;
        for (int i = 0; i < n_acks; i++) begin
            idle($urandom_range(0, 2));
            @(posedge clk); #1;
            host_ack_in = ~host_ack_in;
        end
        if (abort) begin
            send_word(SYNC);
            err_exp = 1'b0;
            settle();
            check("abort_state", IW'(state_out), IW'(1));
            check("abort_ready", IW'(result_ready_out), '0);
        end else begin
            settle();
            check("drain_done_state", IW'(state_out), '0);
            check("drain_done_ready", IW'(result_ready_out), '0);
        end
    endtask

    task automatic check_reset_values();
        check("rst_query", IW'(query_out), '0);
        check("rst_k", IW'(k_out), '0);
        check("rst_valid", IW'(query_valid_out), '0);
        check("rst_result", IW'(result_out), '0);
        check("rst_ready", IW'(result_ready_out), '0);
        check("rst_state", IW'(state_out), '0);
        check("rst_err", IW'(err_out), '0);
    endtask

    task automatic load_query(input logic [31:0] q [DIM]);
        for (int i = 0; i < DIM; i++) send_word(q[i]);
    endtask

    task automatic run_random_txn();
        logic [31:0] q [DIM];
        logic [31:0] kw;
        int k, nb, nacks, npush;
        bit abort;
        if (!in_load) begin
            repeat ($urandom_range(0, 2)) send_word(rand_word());
            send_word(SYNC);
            err_exp = 1'b0;
        end
        in_load = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, DIM)) send_word(rand_word());
            send_word(SYNC);
        end
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        load_query(q);
        kw = {16'($urandom), 16'($urandom_range(0, 7))};
        k  = (kw[15:0] == 16'd0) ? 0 : ((int'(kw[15:0]) > K_MAX) ? K_MAX : int'(kw[15:0]));
        if (k == 0) begin
            send_word(kw);
            settle();
            settle();
            err_exp = 1'b1;
            check("k0_err", IW'(err_out), IW'(err_exp));
            check("k0_state", IW'(state_out), '0);
            return;
        end
        exp_issue_q.push_back(pack_issue(q, k));
        nb    = k + $urandom_range(0, 2);
        abort = ($urandom_range(0, 3) == 0);
        nacks = abort ? $urandom_range(0, k - 1) : k;
        npush = abort ? nacks + 1 : k;
        for (int i = 0; i < nb; i++) beat_vals[i] = $urandom;
        for (int i = 0; i < npush; i++) exp_q.push_back(beat_vals[i]);
        send_word(kw);
        idle($urandom_range(1, 3));
        if ($urandom_range(0, 4) == 0) begin
            send_word(SYNC);
            err_exp = 1'b1;
            settle();
            check("wait_sync_state", IW'(state_out), IW'(3));
        end
        beats(nb, 1'b1);
        drain(nacks, abort, 50);
        if (abort) in_load = 1'b1;
        check("txn_err", IW'(err_out), IW'(err_exp));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] q [DIM];
        bit ok;
        rst_in          = 1'b1;
        host_word_in    = '0;
        host_strobe_in  = 1'b0;
        host_ack_in     = 1'b0;
        result_in       = '0;
        result_valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst_in = 1'b0;

        // Basic query {5,7,1,1}, k=3 with results 10,20,30.
        q = '{32'd5, 32'd7, 32'd1, 32'd1};
        send_word(SYNC);
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 3));
        beat_vals[0] = 32'd10; beat_vals[1] = 32'd20; beat_vals[2] = 32'd30;
        exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd30);
        send_word(32'd3);
        @(negedge clk);
        check("valid_not_early", IW'(query_valid_out), '0);
        @(negedge clk);
        check("valid_cycle_after_k", IW'(query_valid_out), IW'(1));
        beats(3, 1'b0);
        drain(3, 1'b0, 50);

        // Acks with nothing to read are ignored.
        repeat (2) begin
            @(posedge clk); #1;
            host_ack_in = ~host_ack_in;
        end
        settle();
        check("stray_ack_state", IW'(state_out), '0);

        // k word 9 clamps to K_MAX; the fifth beat is dropped.
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        send_word(SYNC);
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, K_MAX));
        for (int i = 0; i < 5; i++) beat_vals[i] = 32'h100 + 32'(i);
        for (int i = 0; i < K_MAX; i++) exp_q.push_back(beat_vals[i]);
        send_word(32'd9);
        idle(1);
        beats(5, 1'b0);
        drain(K_MAX, 1'b0, 50);

        // k word 0: error, no pulse, back to IDLE; the next sync clears the error.
        send_word(SYNC);
        load_query(q);
        send_word(32'd0);
        settle();
        settle();
        check("k0_err_set", IW'(err_out), IW'(1));
        check("k0_idle", IW'(state_out), '0);
        send_word(SYNC);
        settle();
        check("sync_clears_err", IW'(err_out), '0);
        check("sync_to_load", IW'(state_out), IW'(1));

        // Sync after two words restarts the load; then abort the drain after one ack.
        send_word(32'd11);
        send_word(32'd12);
        send_word(SYNC);
        q = '{32'd21, 32'd22, 32'd23, 32'd24};
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 2));
        beat_vals[0] = 32'hA0; beat_vals[1] = 32'hA1;
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
        send_word(32'd2);
        idle(1);
        beats(2, 1'b0);
        drain(1, 1'b1, 50);

        // Sync during WAIT sets the error and leaves the FSM waiting.
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 3));
        for (int i = 0; i < 3; i++) begin
            beat_vals[i] = rand_word();
            exp_q.push_back(beat_vals[i]);
        end
        send_word(32'd3);
        idle(1);
        send_word(SYNC);
        settle();
        check("wait_sync_err", IW'(err_out), IW'(1));
        check("wait_sync_stays", IW'(state_out), IW'(3));
        beats(3, 1'b1);
        drain(3, 1'b0, 50);
        check("err_sticky", IW'(err_out), IW'(1));

        // Ack and sync in the same DRAIN cycle: the sync wins.
        send_word(SYNC);
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 2));
        beat_vals[0] = 32'hB0; beat_vals[1] = 32'hB1;
        exp_q.push_back(32'hB0);
        send_word(32'd2);
        idle(1);
        beats(2, 1'b0);
        wait_ready(50, ok);
        @(posedge clk); #1;
        host_word_in   = SYNC;
        host_strobe_in = ~host_strobe_in;
        host_ack_in    = ~host_ack_in;
        settle();
        check("ack_sync_state", IW'(state_out), IW'(1));
        check("ack_sync_ready", IW'(result_ready_out), '0);
        check("ack_sync_err", IW'(err_out), '0);
        in_load = 1'b1;
        err_exp = 1'b0;

        repeat (25) run_random_txn();

`ifdef BFIS_CTRL_TIMEOUT_EN
        // Two of four beats, then silence: the watchdog drains what arrived.
        if (!in_load) send_word(SYNC);
        in_load = 1'b0;
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 4));
        beat_vals[0] = 32'hC0; beat_vals[1] = 32'hC1;
        exp_q.push_back(32'hC0); exp_q.push_back(32'hC1);
        send_word(32'd4);
        idle(1);
        beats(2, 1'b0);
        drain(2, 1'b0, TIMEOUT_CYCLES + 20);
        check("timeout_err", IW'(err_out), IW'(1));
`endif

        // Reset in the middle of WAIT.
        if (!in_load) send_word(SYNC);
        in_load = 1'b0;
        for (int i = 0; i < DIM; i++) q[i] = rand_word();
        load_query(q);
        exp_issue_q.push_back(pack_issue(q, 2));
        beat_vals[0] = 32'hD0;
        send_word(32'd2);
        idle(1);
        beats(1, 1'b0);
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        check_reset_values();
        idle(3);
        check("post_reset_idle", IW'(state_out), '0);
        check("post_reset_no_issue", IW'(query_valid_out), '0);

        idle(3);
        check("issues_left", IW'(exp_issue_q.size()), '0);
        check("results_left", IW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
